// File: rtl/tcp_vlg_pkg.sv
// Shared types for the tcp_vlg transmit arbiter slice: length and header types
// plus the arbiter FSM state encoding.
package tcp_vlg_pkg;

  typedef logic [15:0] length_t;

  typedef struct packed {
    logic [7:0]  tos;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] id;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } mac_hdr_t;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StXfer,
    StWaitDone
  } arb_state_t;

endpackage

// File: rtl/tcp_vlg_rr_sel.sv
// Request selector: first requesting channel at or after ptr_i (wrapping).
// With TCP_ARB_PRIO_EN defined the lowest-index requester wins and ptr_i is ignored.
module tcp_vlg_rr_sel #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

`ifdef TCP_ARB_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end
`else
  logic [IdxW-1:0] cand;

  // Descending scan over offsets from ptr_i so the smallest offset wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr_i) + i) % N_CH);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end
`endif

endmodule

// File: rtl/tcp_vlg_tx_arb.sv
// Packet-level arbiter merging N_CH TCP transmit streams onto one ipv4 tx path.
// One channel is granted per packet; its length and headers are latched for the packet.
// Grant timeout and length watchdog raise a per-channel drop pulse.
// Build option TCP_ARB_PRIO_EN selects fixed priority instead of round-robin.
module tcp_vlg_tx_arb
  import tcp_vlg_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned MAX_LEN     = 1460,
  parameter int unsigned GNT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      in_req,
  output logic [N_CH-1:0]      in_gnt,
  input  logic [N_CH*8-1:0]    in_d,
  input  logic [N_CH-1:0]      in_v,
  input  logic [N_CH-1:0]      in_sof,
  input  logic [N_CH-1:0]      in_eof,
  input  logic [N_CH*16-1:0]   in_len,
  input  ipv4_hdr_t            in_ipv4_hdr [N_CH],
  input  mac_hdr_t             in_mac_hdr  [N_CH],
  output logic [N_CH-1:0]      in_done,
  output logic [N_CH-1:0]      drop,
  output logic [7:0]           out_d,
  output logic                 out_v,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_err,
  output length_t              out_len,
  output ipv4_hdr_t            out_ipv4_hdr,
  output mac_hdr_t             out_mac_hdr,
  input  logic                 out_busy,
  input  logic                 out_done
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick_idx, next_ptr;
  logic [N_CH-1:0] gnt_q, gnt_d, drop_q, drop_d, done_q, done_d, pick_gnt;
  logic            pick_valid;
  logic [15:0]     cnt_q, cnt_d, byte_q, byte_d, byte_inc;
  logic [7:0]      od_q, od_d;
  logic            ov_q, ov_d, osof_q, osof_d, oeof_q, oeof_d, oerr_q, oerr_d;
  logic            fwd_v, trunc;
  length_t         len_q, len_d;
  ipv4_hdr_t       ip_q, ip_d;
  mac_hdr_t        mac_q, mac_d;

  tcp_vlg_rr_sel #(
    .N_CH (N_CH),
    .IdxW (IdxW)
  ) u_sel (
    .req_i   (in_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign next_ptr = (sel_q == IdxW'(N_CH - 1)) ? '0 : sel_q + 1'b1;

  // Next-state, grant bookkeeping and the one-register data pipeline.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    len_d    = len_q;
    ip_d     = ip_q;
    mac_d    = mac_q;
    drop_d   = '0;
    done_d   = '0;

    // Bytes before sof in GRANT are not forwarded; the sof byte starts the count.
    fwd_v    = in_v[sel_q] & ((state_q == StXfer) | ((state_q == StGrant) & in_sof[sel_q]));
    byte_inc = ((state_q == StGrant) ? 16'd0 : byte_q) + 16'd1;
    trunc    = fwd_v & ~in_eof[sel_q] & (byte_inc == 16'(MAX_LEN));

    od_d   = fwd_v ? in_d[8*sel_q +: 8] : 8'd0;
    ov_d   = fwd_v;
    osof_d = fwd_v & in_sof[sel_q];
    oeof_d = fwd_v & (in_eof[sel_q] | trunc);
    oerr_d = trunc;

    unique case (state_q)
      StIdle: begin
        if (pick_valid && !out_busy) begin
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
          len_d   = in_len[16*pick_idx +: 16];
          ip_d    = in_ipv4_hdr[pick_idx];
          mac_d   = in_mac_hdr[pick_idx];
          cnt_d   = '0;
          byte_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant, StXfer: begin
        if (state_q == StGrant) cnt_d = cnt_q + 16'd1;
        if (fwd_v) begin
          byte_d = byte_inc;
          if (in_eof[sel_q] || trunc) begin
            gnt_d         = '0;
            drop_d[sel_q] = trunc;
            state_d       = StWaitDone;
          end else begin
            state_d = StXfer;
          end
        end else if (state_q == StGrant && cnt_q == 16'(GNT_TIMEOUT - 1)) begin
          drop_d[sel_q] = 1'b1;
          gnt_d         = '0;
          rr_ptr_d      = next_ptr;
          state_d       = StIdle;
        end
      end
      StWaitDone: begin
        if (out_done) begin
          done_d[sel_q] = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      len_q    <= '0;
      ip_q     <= '0;
      mac_q    <= '0;
      drop_q   <= '0;
      done_q   <= '0;
      od_q     <= '0;
      ov_q     <= 1'b0;
      osof_q   <= 1'b0;
      oeof_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      len_q    <= len_d;
      ip_q     <= ip_d;
      mac_q    <= mac_d;
      drop_q   <= drop_d;
      done_q   <= done_d;
      od_q     <= od_d;
      ov_q     <= ov_d;
      osof_q   <= osof_d;
      oeof_q   <= oeof_d;
      oerr_q   <= oerr_d;
    end
  end

  assign in_gnt       = gnt_q;
  assign in_done      = done_q;
  assign drop         = drop_q;
  assign out_d        = od_q;
  assign out_v        = ov_q;
  assign out_sof      = osof_q;
  assign out_eof      = oeof_q;
  assign out_err      = oerr_q;
  assign out_len      = len_q;
  assign out_ipv4_hdr = ip_q;
  assign out_mac_hdr  = mac_q;

endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// Directed bench for tcp_vlg_tx_arb (N_CH=4, MAX_LEN=16, GNT_TIMEOUT=64).
module tb_tcp_vlg_tx_arb;
  import tcp_vlg_pkg::*;

  localparam int unsigned NCh    = 4;
  localparam int unsigned MaxLen = 16;
  localparam int unsigned GntTo  = 64;
`ifdef TCP_ARB_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCh-1:0]    in_req, in_gnt, in_v, in_sof, in_eof, in_done, drop;
  logic [NCh*8-1:0]  in_d;
  logic [NCh*16-1:0] in_len;
  ipv4_hdr_t         in_ipv4_hdr [NCh];
  mac_hdr_t          in_mac_hdr  [NCh];
  logic [7:0]        out_d;
  logic              out_v, out_sof, out_eof, out_err, out_busy, out_done;
  length_t           out_len;
  ipv4_hdr_t         out_ipv4_hdr;
  mac_hdr_t          out_mac_hdr;

  int checks = 0;
  int errors = 0;
  int lens [NCh] = '{20, 4, 10, 4};

  always #5 clk = ~clk;

  tcp_vlg_tx_arb #(
    .N_CH        (NCh),
    .MAX_LEN     (MaxLen),
    .GNT_TIMEOUT (GntTo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_req       (in_req),
    .in_gnt       (in_gnt),
    .in_d         (in_d),
    .in_v         (in_v),
    .in_sof       (in_sof),
    .in_eof       (in_eof),
    .in_len       (in_len),
    .in_ipv4_hdr  (in_ipv4_hdr),
    .in_mac_hdr   (in_mac_hdr),
    .in_done      (in_done),
    .drop         (drop),
    .out_d        (out_d),
    .out_v        (out_v),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_err      (out_err),
    .out_len      (out_len),
    .out_ipv4_hdr (out_ipv4_hdr),
    .out_mac_hdr  (out_mac_hdr),
    .out_busy     (out_busy),
    .out_done     (out_done)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any grant, then checks it and the latched packet info.
  task automatic wait_gnt(input int ch);
    int n = 0;
    while (in_gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("gnt", 64'(in_gnt), 64'(1) << ch);
    chk("len", 64'(out_len), 64'(lens[ch]));
    chk("ip_src", 64'(out_ipv4_hdr.src_ip), 64'(32'hC0A8_0100 + ch));
  endtask

  // Drives an n-byte packet on ch and checks the 1-cycle delayed merged output.
  task automatic send_pkt(input int ch, input int n, input logic [7:0] base);
    int last = (n > int'(MaxLen)) ? int'(MaxLen) - 1 : n - 1;
    for (int i = 0; i < n; i++) begin
      in_v[ch]         = 1'b1;
      in_sof[ch]       = (i == 0);
      in_eof[ch]       = (i == n - 1);
      in_d[8*ch +: 8]  = base + 8'(i);
      tick();
      if (i <= last) begin
        chk("out_v", 64'(out_v), 64'd1);
        chk("out_d", 64'(out_d), 64'(base + 8'(i)));
        chk("out_sof", 64'(out_sof), 64'(i == 0));
        chk("out_eof", 64'(out_eof), 64'(i == last));
        if (i == 0) chk("gnt_hold", 64'(in_gnt), 64'(1) << ch);
        if (i == last) begin
          chk("out_err", 64'(out_err), 64'(n > int'(MaxLen)));
          chk("drop", 64'(drop), (n > int'(MaxLen)) ? (64'(1) << ch) : 64'd0);
          chk("gnt_clr", 64'(in_gnt), 64'd0);
        end
      end else begin
        chk("trunc_v", 64'(out_v), 64'd0);
      end
    end
    in_v[ch]   = 1'b0;
    in_sof[ch] = 1'b0;
    in_eof[ch] = 1'b0;
    tick();
    chk("idle_v", 64'(out_v), 64'd0);
  endtask

  task automatic done_pulse(input int ch);
    out_done = 1'b1;
    tick();
    chk("in_done", 64'(in_done), 64'(1) << ch);
    chk("turn_gnt", 64'(in_gnt), 64'd0);
    out_done = 1'b0;
    tick();
    chk("in_done_clr", 64'(in_done), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_ch;
    int cyc;
    int gc;
    in_req   = '0;
    in_v     = '0;
    in_sof   = '0;
    in_eof   = '0;
    in_d     = '0;
    out_busy = 1'b0;
    out_done = 1'b0;
    for (int c = 0; c < int'(NCh); c++) begin
      in_len[16*c +: 16]       = 16'(lens[c]);
      in_ipv4_hdr[c]           = '0;
      in_ipv4_hdr[c].src_ip    = 32'hC0A8_0100 + 32'(c);
      in_mac_hdr[c]            = '0;
      in_mac_hdr[c].src_mac    = 48'h0200_0000_0000 + 48'(c);
    end

    // Reset state.
    #2;
    chk("rst_gnt", 64'(in_gnt), 64'd0);
    chk("rst_v", 64'(out_v), 64'd0);
    chk("rst_len", 64'(out_len), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_done", 64'(in_done), 64'd0);
    tick();
    rst = 1'b0;

    // Single requester ch2, with ungranted noise on ch0.
    in_v[0] = 1'b1; in_sof[0] = 1'b1; in_d[7:0] = 8'hEE;
    in_req = 4'b0100;
    tick();
    chk("t1_gnt", 64'(in_gnt), 64'h4);
    chk("t1_len", 64'(out_len), 64'd10);
    chk("t1_mac", 64'(out_mac_hdr.src_mac), 64'h0200_0000_0002);
    in_req = '0;
    send_pkt(2, 10, 8'hA0);
    done_pulse(2);
    in_v[0] = 1'b0; in_sof[0] = 1'b0;

    // All channels requesting continuously.
    do_reset();
    in_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ch = Prio ? 0 : (k % 4);
      wait_gnt(exp_ch);
      send_pkt(exp_ch, 4, 8'(16 * k));
      if (k == 4) in_req = '0;
      done_pulse(exp_ch);
    end

    // Grant timeout on ch1 (never sends sof); ch3 also requesting.
    do_reset();
    in_req = 4'b1010;
    wait_gnt(1);
    cyc = 0;
    while (drop == '0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("to_cycles", 64'(cyc), 64'(GntTo));
    chk("to_drop", 64'(drop), 64'h2);
    chk("to_gnt", 64'(in_gnt), 64'd0);
    gc = Prio ? 1 : 3;
    wait_gnt(gc);

    // Reset in the middle of a transfer.
    in_req = '0;
    for (int i = 0; i < 3; i++) begin
      in_v[gc] = 1'b1;
      in_sof[gc] = (i == 0);
      in_d[8*gc +: 8] = 8'h30 + 8'(i);
      tick();
    end
    chk("mid_v", 64'(out_v), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst_gnt", 64'(in_gnt), 64'd0);
    chk("mrst_v", 64'(out_v), 64'd0);
    chk("mrst_d", 64'(out_d), 64'd0);
    chk("mrst_len", 64'(out_len), 64'd0);
    in_v = '0;
    in_sof = '0;
    tick();
    tick();
    rst = 1'b0;

    // ch0 and ch3 requesting continuously after reset.
    in_req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      exp_ch = (Prio || k != 1) ? 0 : 3;
      wait_gnt(exp_ch);
      send_pkt(exp_ch, 4, 8'h60 + 8'(16 * k));
      if (k == 2) in_req = 4'b0001;
      done_pulse(exp_ch);
    end

    // Watchdog truncation: 20-byte packet with MAX_LEN 16.
    wait_gnt(0);
    in_req = '0;
    send_pkt(0, 20, 8'hC0);
    done_pulse(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_tx_arb.md
Name: tcp_vlg_tx_arb

Overview:
Packet-level arbiter that merges N per-connection TCP transmit streams (one per tcp_vlg socket instance) onto the single ipv4 tx path. Successor to the single-connection tcp_vlg top, generalised in channel count. Grants one channel per packet and latches that channel's headers and length for the whole packet. Adds a grant timeout, a length watchdog and per-channel drop flags.

Parameters:
N_CH, 4, number of connection channels (2..16)
MAX_LEN, 1460, maximum payload bytes per packet before the watchdog truncates it
GNT_TIMEOUT, 64, cycles a granted channel has to assert sof before the grant is revoked

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_req  in  N_CH  channel has a packet pending (level, held until granted)
in_gnt  out  N_CH  one-hot grant
in_d  in  N_CH*8  channel data, channel k at [8k+7:8k]
in_v  in  N_CH  channel data valid
in_sof  in  N_CH  channel start of packet
in_eof  in  N_CH  channel end of packet
in_len  in  N_CH*16  channel payload length (length_t)
in_ipv4_hdr  in  [N_CH] ipv4_hdr_t  channel IPv4 header, unpacked array
in_mac_hdr  in  [N_CH] mac_hdr_t  channel MAC header, unpacked array
in_done  out  N_CH  one-cycle pulse to the granted channel when out_done is seen
drop  out  N_CH  one-cycle pulse: channel's grant timed out or packet was truncated
out_d  out  8  merged data
out_v  out  1  merged valid
out_sof  out  1  merged start of packet
out_eof  out  1  merged end of packet
out_err  out  1  asserted with out_eof on watchdog truncation
out_len  out  16  latched payload length
out_ipv4_hdr  out  ipv4_hdr_t  latched header
out_mac_hdr  out  mac_hdr_t  latched header
out_busy  in  1  ipv4 tx busy
out_done  in  1  ipv4 tx finished packet

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. rr_ptr=0. Counters are 0. Reset mid-packet abandons the packet with no eof.
- FSM states: IDLE, GRANT, XFER, WAIT_DONE.
- IDLE: when any in_req is set and out_busy=0, select the first requesting channel at or after rr_ptr, with wrap-around modulo N_CH. On the next clock:
  - in_gnt[sel] rises;
  - out_len, out_ipv4_hdr and out_mac_hdr latch channel sel's values;
  - go to GRANT.
- GRANT: a timeout counter increments each cycle.
  - in_sof[sel]&in_v[sel] seen -> go to XFER.
  - Counter reaches GNT_TIMEOUT-1 without sof -> drop[sel] pulses, in_gnt clears, rr_ptr=sel+1, return to IDLE.
- Data path: one-register pipeline. out_d, out_v, out_sof and out_eof equal the selected channel's inputs delayed 1 cycle. Non-granted channels' data is ignored.
- XFER: a byte counter (16 bit) increments on each out_v.
  - in_eof[sel] -> go to WAIT_DONE; in_gnt clears on the cycle after eof.
  - Byte count reaches MAX_LEN without eof -> force out_eof=1 and out_err=1 on that byte, pulse drop[sel], clear in_gnt, ignore the rest of that channel's packet, go to WAIT_DONE.
- WAIT_DONE: on out_done, in_done[sel] pulses 1 cycle, rr_ptr=sel+1 mod N_CH, return to IDLE. Minimum turnaround from out_done to the next grant is 2 cycles.
- in_req deasserting after grant has no effect; the packet is still awaited until timeout.
- sof while already in XFER (a channel protocol error) is passed through and does not reset the byte counter.
- Simultaneous requests: only one grant at a time. in_gnt is always one-hot or zero.

Optional Feature:
TCP_ARB_PRIO_EN
- Defined: fixed priority; the lowest-index requesting channel always wins and rr_ptr is unused. Intended for a control/keepalive channel on index 0.
- Undefined: round-robin as described in Behaviour.
- All timing and the timeout/watchdog behaviour are identical in both modes.

Decomposition:
- tcp_vlg_pkg: typedef arb_state_t (the 4 FSM states).
- Existing length_t, ipv4_hdr_t and mac_hdr_t come from ip_vlg_pkg, mac_vlg_pkg and eth_vlg_pkg.
- One sub-module, tcp_vlg_rr_sel: combinational request vector plus pointer -> one-hot select and index, with the priority mode under the macro.

Test Plan:
- N_CH=4; only ch2 requests with a 10-byte packet -> in_gnt=4'b0100 one cycle later; out_* mirror ch2 delayed 1 cycle; out_len=10; in_done[2] pulses after out_done.
- All 4 channels request continuously with 4-byte packets -> grant order 0,1,2,3,0; no overlap of in_gnt bits.
- ch1 granted but never asserts sof, GNT_TIMEOUT=64 -> drop[1] pulses 64 cycles after the grant; the grant then moves to the next requester.
- MAX_LEN=16; ch0 sends 20 bytes -> out_eof=1 and out_err=1 on the 16th out byte; drop[0] pulses; bytes 17-20 are not forwarded.
- rst asserted mid-XFER -> all outputs are 0 immediately; the next packet after release is granted from ch0.
- TCP_ARB_PRIO_EN defined; ch0 and ch3 requesting continuously -> ch0 is granted every time and ch3 is never granted.
